tick_meter: RTL
===============

# tick_meter

Measures the interval, in `clk` cycles, between consecutive rising edges of a pulse stream (`tick_in`) and reports each completed period with a one-cycle valid strobe. It is the receiving end of the game's tick/strobe pulses: it checks pulse rates, drives on-screen debug counters, and flags a stalled tick source via a timeout. It sits in the timing/control layer, beside the pulse generators it monitors.

## Interface
- `WIDTH`, 32, width of the internal counter and the `period` output.
- `TIMEOUT`, 100_000_000, largest reportable period in cycles; legal range 2 ≤ TIMEOUT ≤ 2^WIDTH−1.
- `clk`  input  1  clock; all logic on posedge.
- `resetn`  input  1  reset, synchronous, active-low.
- `tick_in`  input  1  pulse stream to measure; any high time ≥1 cycle.
- `period`  output  WIDTH  last measured period in cycles; held between updates.
- `period_valid`  output  1  one-cycle strobe; `period` updated this cycle.
- `locked`  output  1  at least one valid period measured since the last reset or timeout.
- `timeout`  output  1  no edge for TIMEOUT cycles; level, held until the next edge.

## Operation
- Edge detect: `tick_q` is `tick_in` (see Configuration). `tick_prev <= tick_q`; edge = `tick_q & ~tick_prev`. `tick_prev` resets to 1, so a level held high through reset is not an edge.
- Counter `cnt` (WIDTH bits): increments by 1 each cycle in MEASURE; cleared to 0 on every edge; frozen in IDLE/STALE.
- FSM states:
  - IDLE: no edge since reset. On edge → MEASURE, cnt=0, no report.
  - MEASURE: on edge → period=cnt+1, period_valid=1, locked=1, cnt=0, stay. Else if cnt==TIMEOUT−1 → STALE, timeout=1, locked=0.
  - STALE: on edge → MEASURE, cnt=0, timeout=0, no report (first edge after a stall is a fresh start).
- Period semantics: edges sampled at clock edges t0 and t1 give period = t1−t0. A pulse on every cycle is impossible (needs a low cycle); min reportable period = 2.
- Simultaneous edge and cnt==TIMEOUT−1 in MEASURE: edge wins; period=TIMEOUT reported, no timeout.
- Arithmetic: cnt+1 computed at WIDTH bits; it cannot overflow because cnt never exceeds TIMEOUT−1.
- Reset (any state, mid-measure included): state=IDLE, cnt=0, period=0, period_valid=0, locked=0, timeout=0, tick_prev=1.

## Timing
- Without sync: edge sampled at clock edge k → `period`, `period_valid`, `locked` updated after edge k (1-cycle latency from `tick_in` rising).
- With sync: latency 3 cycles (2 synchronizer stages + 1); measured periods unchanged.
- `period_valid` is never high two cycles in a row.
- `timeout` rises TIMEOUT cycles after the last edge was sampled; falls one cycle after the next edge is sampled.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `TICK_METER_SYNC_EN`: defined → `tick_in` passes through a 2-flop synchronizer (reset to 1) before edge detection, for asynchronous sources (keys, GPIO). Undefined → `tick_in` used directly; the source must be synchronous to `clk`.

## Structure
- Package `tick_meter_pkg`: state typedef (IDLE, MEASURE, STALE), 2-bit encoding; default WIDTH/TIMEOUT constants.
- Sub-module `edge_sync`: optional synchronizer + `tick_prev` register + edge output; the top holds the FSM, counter and output registers.

## Test plan
- Pulse 1 cycle high every 5 clocks → first edge gives no strobe; every later edge gives period=5 with a 1-cycle `period_valid`; `locked`=1 after the second edge.
- Pulses high 3 cycles, period 7 → period=7; only rising edges counted, one strobe per pulse.
- TIMEOUT=10, one edge then silence → `timeout`=1 exactly 10 cycles after the edge, `locked`=0; next edge clears `timeout`, no strobe; following edge at +4 → period=4.
- TIMEOUT=10, edges exactly 10 apart → period=10 reported, `timeout` never asserts.
- `tick_in` held high through reset release → no edge detected; `resetn` low mid-measure → all outputs 0, FSM IDLE, next edge produces no strobe.
- With `TICK_METER_SYNC_EN` defined, repeat scenario 1 → same period=5, strobes 2 cycles later.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared types and defaults for tick_meter: FSM state encoding and default sizing.
package tick_meter_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALE   = 2'd2
  } state_e;

endpackage : tick_meter_pkg

// File: rtl/tick_meter_edge_sync.sv
// Rising-edge detector for tick_meter, with an optional 2-flop synchronizer
// enabled by TICK_METER_SYNC_EN for sources asynchronous to clk.
module edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic tick_i,
  output logic rise_c_o
);

  logic tick_q;
  logic tick_prev_q;

`ifdef TICK_METER_SYNC_EN
  // Resets high so a level already high at reset release is not seen as a rise.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], tick_i};
    end
  end

  assign tick_q = sync_q[1];
`else
  assign tick_q = tick_i;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_prev_q <= 1'b1;
    end else begin
      tick_prev_q <= tick_q;
    end
  end

  assign rise_c_o = tick_q & ~tick_prev_q;

endmodule : edge_sync

// File: rtl/tick_meter.sv
// Measures clk cycles between rising edges of tick_in, strobes each period and
// flags a stalled source. Optional input synchronizer: TICK_METER_SYNC_EN.
module tick_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 32'd1);

  logic             rise_c;
  state_e           state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             locked_q, locked_d;
  logic             tmo_q,    tmo_d;

  edge_sync u_edge_sync (
    .clk      (clk),
    .resetn   (resetn),
    .tick_i   (tick_in),
    .rise_c_o (rise_c)
  );

  // Next-state: an edge always takes priority over the timeout check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end
      end
      ST_MEASURE: begin
        if (rise_c) begin
          period_d = cnt_q + WIDTH'(1);
          valid_d  = 1'b1;
          locked_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_STALE;
          tmo_d    = 1'b1;
          locked_d = 1'b0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      ST_STALE: begin
        if (rise_c) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = tmo_q;

endmodule : tick_meter
